// File: rtl/fb_gate_gain.sv
// ---------------------------------------------------------------------------
// fb_gate_gain
//   Gated, scaled and saturated feedback sample path. A rising edge on trig
//   arms one gate window: after start_dly cycles the window opens for
//   win_len cycles. Samples taken inside the window are multiplied by a
//   Q2.5 gain, scaled back by 2^5, saturated to 13 bits and presented on
//   dout with dout_valid two cycles later. Outside the window dout is zero.
//
//   Configuration macro: FB_ROUND_EN
//     defined   -> round half up (add 16 before the >>>5)
//     undefined -> floor (plain arithmetic shift)
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   trig       in   1       rising edge arms one gate window
//   din        in   13 s    delayed sample from upstream shift register
//   gain       in   7  s    Q2.5 gain, 32 = unity
//   start_dly  in   8       cycles from trig edge to window open
//   win_len    in   8       window length in cycles
//   dout       out  13 s    gated, scaled, saturated sample
//   dout_valid out  1       dout carries an in-window sample
//   busy       out  1       gate FSM not idle
// ---------------------------------------------------------------------------
module fb_gate_gain (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic signed [12:0] din,
  input  logic signed [6:0]  gain,
  input  logic [7:0]         start_dly,
  input  logic [7:0]         win_len,
  output logic signed [12:0] dout,
  output logic               dout_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

`ifdef FB_ROUND_EN
  localparam logic signed [20:0] RND_BIAS = 21'sd16;
`else
  localparam logic signed [20:0] RND_BIAS = 21'sd0;
`endif

  localparam logic signed [20:0] SAT_MAX = 21'sd4095;
  localparam logic signed [20:0] SAT_MIN = -21'sd4096;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic               w_load_cfg;

  logic               r_trig_q;
  logic               r_low_ok;   // a registered low has been seen since reset
  logic               w_edge;

  logic [7:0]         r_win_len;
  logic signed [6:0]  r_gain;

  logic signed [19:0] w_prod;
  logic signed [19:0] r_prod;
  logic               r_v1;
  logic signed [20:0] w_sum;
  logic signed [20:0] w_shift;
  logic signed [12:0] w_sat;

  // A level held high through reset release must not look like an edge, so
  // the edge also requires that trig has been observed low at least once.
  assign w_edge = trig & ~r_trig_q & r_low_ok;
  assign busy   = (r_state != S_IDLE);

  // -------------------------------------------------------------------------
  // Gate FSM: next state / counter
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_cfg  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_load_cfg = 1'b1;
          if (start_dly != 8'd0) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = start_dly;
          end else if (win_len != 8'd0) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = win_len;
          end else begin
            // Zero delay and zero length still spends one busy cycle.
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = 8'd1;
          end
        end
      end

      S_DELAY: begin
        if (r_cnt == 8'd1) begin
          if (r_win_len != 8'd0) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = r_win_len;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_ACTIVE: begin
        if (r_cnt == 8'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath arithmetic
  // -------------------------------------------------------------------------
  assign w_prod  = din * r_gain;
  assign w_sum   = {r_prod[19], r_prod} + RND_BIAS;
  assign w_shift = w_sum >>> 5;

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_sat = 13'sd4095;
    end else if (w_shift < SAT_MIN) begin
      w_sat = -13'sd4096;
    end else begin
      w_sat = w_shift[12:0];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the pipeline registers are reset too, otherwise a sample in
      // flight when reset hits could still be emitted afterwards.
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_trig_q   <= 1'b0;
      r_low_ok   <= ~trig;
      r_win_len  <= 8'd0;
      r_gain     <= 7'sd0;
      r_prod     <= 20'sd0;
      r_v1       <= 1'b0;
      dout       <= 13'sd0;
      dout_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_trig_q <= trig;
      r_low_ok <= r_low_ok | ~trig;

      if (w_load_cfg) begin
        r_win_len <= win_len;
        r_gain    <= gain;
      end

      // Stage 1: product plus the gate bit that travels with it.
      r_prod <= w_prod;
      r_v1   <= (r_state == S_ACTIVE);

      // Stage 2: scaled, saturated and gated output.
      dout       <= r_v1 ? w_sat : 13'sd0;
      dout_valid <= r_v1;
    end
  end

endmodule

// File: doc/fb_gate_gain.md
FB_GATE_GAIN -- requirements
Module: fb_gate_gain

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have: trig  in  1  pulse-train start; rising edge arms one gate window.
REQ-004 SHALL have: din  in  13 signed  delayed sample from the upstream programmable shift register.
REQ-005 SHALL have: gain  in  7 signed  Q2.5 (32 = unity; range -2.0 to +1.96875).
REQ-006 SHALL have: start_dly  in  8  cycles from trig edge to window open.
REQ-007 SHALL have: win_len  in  8  window length in cycles.
REQ-008 SHALL have: dout  out  13 signed  gated, scaled, saturated sample to the DAC path.
REQ-009 SHALL have: dout_valid  out  1  high when dout carries an in-window sample.
REQ-010 SHALL have: busy  out  1  high when state is not IDLE.

Function
REQ-011 SHALL register trig once; edge = trig & ~trig_q; a level held high arms only one window.
REQ-012 SHALL implement FSM IDLE, DELAY, ACTIVE; busy = (state != IDLE).
REQ-013 SHALL latch start_dly, win_len and gain on the accepted edge; later changes have no effect until the next window.
REQ-014 Edge at cycle 0 in IDLE: start_dly=D>0 -> DELAY for cycles 1..D; ACTIVE for cycles D+1..D+W (W = win_len); IDLE from D+W+1.
REQ-015 D=0 -> ACTIVE directly from cycle 1; W=0 -> no ACTIVE cycles, return to IDLE after DELAY (or at cycle 1 if D=0 too), dout_valid never asserts.
REQ-016 Edges while busy (including the last ACTIVE cycle) SHALL be ignored; an edge in the first IDLE cycle SHALL be accepted.
REQ-017 Datapath: stage 1 registers din*gain_latched (20-bit signed); stage 2 scales, saturates and registers dout; latency din->dout = 2 cycles.
REQ-018 Scaling: arithmetic right shift by 5, rounding per REQ-026; saturate to [-4096, +4095].
REQ-019 Gate SHALL be pipelined with the data: din sampled in an ACTIVE cycle appears on dout with dout_valid=1 two cycles later; valid cycles are D+3..D+W+2.
REQ-020 Outside valid cycles dout SHALL be 13'sd0.

Reset
REQ-021 rst SHALL force state=IDLE, trig_q=0, latched config=0, pipeline=0.
REQ-022 Outputs after reset: dout=0, dout_valid=0, busy=0 from the first cycle following the rst-high edge.
REQ-023 rst mid-window SHALL abort immediately; in-flight samples SHALL be discarded, never emitted.
REQ-024 A trig edge coinciding with rst SHALL be ignored; trig held high through rst release SHALL NOT arm a window (trig_q reset to 0 only counts after one registered low).

Configuration
REQ-025 Macro FB_ROUND_EN selects the rounding mode.
REQ-026 Defined: add 16 to the product before the shift (round half up). Undefined: plain arithmetic shift (floor). Saturation and timing are identical either way.

Verification
REQ-027 D=3, W=4, gain=32, din ramp 0,1,2,...: busy cycles 1..7; dout_valid cycles 6..9; dout equals din of cycles 4..7.
REQ-028 gain=63, din=4095 -> dout=4095 (saturated); gain=-64, din=-4096 -> dout=4095; gain=-64, din=4095 -> dout=-4096.
REQ-029 gain=16: din=1 -> 1 with FB_ROUND_EN, 0 without; din=-1 -> 0 with, -1 without.
REQ-030 D=0, W=0 edge -> busy high one cycle only, dout_valid never high; D=0, W=1 -> single valid cycle at 3.
REQ-031 Second trig edge during ACTIVE ignored; edge in the first IDLE cycle starts a new window with identical timing.
REQ-032 rst asserted at cycle D+2 of a W=10 window -> dout=0, dout_valid=0, busy=0 the next cycle; no residual valid samples.
